mx_block_scan: RTL and testbench
================================

# mx_block_scan

Upstream stage of the FP32→MX (E3M2) converter. Accepts a stream of FP32 elements and buffers one 32-element block. It computes the block's shared E8M0 scale `X` and replays each element as the 12-bit pre-quantised word `V_i` = {sign, exp[7:0], mant[2:0]}, paired with `X`, into the per-element E3M2 encoder. Ping-pong buffering lets a new block be filled while the previous one drains.

## Interface
Parameters:
- `N_ELEM`, default 32: elements per MX block; must be a power of 2.
- `EMAX_ELEM`, default 4: emax of the element format, subtracted from the block max exponent.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `in_data` in 32: FP32 element.
- `out_valid` out 1: `out_v`, `out_x`, `out_idx` and `out_last` are valid.
- `out_ready` in 1: downstream accepts the output this cycle.
- `out_v` out 12: {sign, exp[7:0], mant[22:20]} of the element.
- `out_x` out 8: shared scale of the current output block.
- `out_idx` out log2(N_ELEM): element index within the block.
- `out_last` out 1: asserted with element `N_ELEM-1`.

## Operation
- **Input transfer** occurs when `in_valid && in_ready`.
- **Storage:** the 12-bit `V` word is written to the fill bank at the write index.
- **Running maximum:** the fill bank tracks `emax` over exp[7:0], and `special` = any exp == 8'hFF.
- **Shared scale on block close:** when element `N_ELEM-1` is accepted, `X` for that bank is latched:
  - `X` = 8'hFF if `special`;
  - otherwise `X` = `emax` − `EMAX_ELEM`, saturating at 0 (e.g. `emax`=3 → `X`=0).
- **Bank states** (per bank): EMPTY → FILLING on the first accept; FILLING → FULL on the last accept; FULL → EMPTY on the last output transfer.
- **Fill pointer:** after a bank fills, the fill pointer toggles to the other bank.
- **Drain pointer:** the drain pointer starts at bank 0 and toggles after each block's last output transfer.
- **`in_ready`:** high iff the fill bank is not FULL.
- **Output:** `out_valid` is high iff the drain bank is FULL. An output transfer occurs on `out_valid && out_ready`, then the read index advances.
- **Output stability:** `out_x` is constant across all elements of a block. Outputs hold while `out_valid && !out_ready`.
- **Same bank, same cycle:** if a bank's last output transfer and the first input accept to that same bank fall in the same cycle, both take effect. The bank ends FILLING.
- **Mid-block reset:** `rst` discards all partial and full blocks. No partial block is ever emitted.
- **Subnormal/zero inputs:** inputs with exp == 0 pass through unchanged; `V` holds the raw exponent 0.

## Timing
- **Reset values:**
  - `in_ready`=1, `out_valid`=0;
  - `out_v`=0, `out_x`=0, `out_idx`=0, `out_last`=0;
  - both banks EMPTY; both pointers at bank 0; write and read indices 0; `emax`=0; `special`=0.
- **Latency:** `out_valid` rises in the cycle after the accept of element `N_ELEM-1`. `out_x` is valid in that same cycle.
- **Throughput:** 1 element/cycle sustained on both sides with `PINGPONG` enabled.
- **Output registering:** outputs are registered; there is no combinational path from `in_data` to `out_*`. `in_ready` depends only on registered state.

## Configuration
- `MX_SCAN_PINGPONG_EN`
  - **Defined:** two banks, operating as above.
  - **Undefined:** a single bank. `in_ready`=0 from the last accept until the last output transfer of that block completes. Minimum block period is 2·`N_ELEM` cycles.

## Structure
- **Shared package** (`mx_pkg`), holding:
  - FP32 field widths/offsets (sign 31, exp 30:23, mant 22:0);
  - the `V` word typedef (12 bits);
  - the E8M0 NaN constant 8'hFF;
  - `EMAX_ELEM` for E3M2.
- **Sub-module:** one natural sub-module, `mx_scan_bank`, containing storage, `emax`/`special` accumulation, the `X` latch and the state for one bank. It is instantiated once or twice depending on `MX_SCAN_PINGPONG_EN`.

## Test plan
- **All ones:** 32× 0x3F800000 (1.0) → `out_x`=8'd123; every `out_v`=12'h3F8; `out_idx` 0..31; `out_last` only on idx 31.
- **Mixed block:** 31× 0x3F800000 plus 1× 0x7F800000 (+Inf) → `out_x`=8'hFF; Inf element `out_v`=12'h7F8.
- **All zero:** 32× 0x00000000 → `out_x`=0 (saturation); all `out_v`=0.
- **Backpressure:** `out_ready`=0 for 80 cycles with continuous input.
  - With `PINGPONG`: exactly 64 accepts, then `in_ready`=0.
  - Without `PINGPONG`: 32 accepts.
  - No data loss or reorder after release.
- **Mid-block reset:** assert `rst` after 10 accepts; refill with a block of 0x40000000 (2.0) → `out_x`=8'd124; no stale elements emitted.
- **Back-to-back:** blocks with `emax` 130 then 100 streamed back-to-back with `out_ready`=1 → `out_x`=126 for the first block, then 96, switching exactly at `out_idx`=0 of the second block.

Source files
------------

// File: rtl/mx_pkg.sv
// Shared definitions for the FP32 -> MX (E3M2) converter: FP32 field layout,
// the 12-bit pre-quantised V word, E8M0 constants and per-bank state encoding.
package mx_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MANT_MSB = 22;

    localparam int EXP_W    = 8;
    localparam int V_MANT_W = 3;

    localparam logic [EXP_W-1:0] E8M0_NAN = 8'hFF;

    // Largest unbiased exponent representable by E3M2.
    localparam int EMAX_E3M2 = 4;

    typedef struct packed {
        logic                sign;
        logic [EXP_W-1:0]    exp;
        logic [V_MANT_W-1:0] mant;
    } v_word_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

endpackage

// File: rtl/mx_scan_bank.sv
// One block buffer: element storage, running exponent max / special flag,
// the latched shared scale X and the EMPTY/FILLING/FULL state of the bank.
module mx_scan_bank
    import mx_pkg::*;
#(
    parameter int N_ELEM    = 32,
    parameter int EMAX_ELEM = EMAX_E3M2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(N_ELEM)-1:0] wr_idx,
    input  v_word_t                   wr_v,
    input  logic [$clog2(N_ELEM)-1:0] rd_idx,
    input  logic                      rd_done,
    output logic                      full,
    output v_word_t                   rd_v,
    output logic [EXP_W-1:0]          x
);

    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [EXP_W-1:0] EMAX_L   = EXP_W'(EMAX_ELEM);

    bank_state_e      state, state_nxt;
    v_word_t          mem [N_ELEM];
    logic [EXP_W-1:0] emax, emax_upd;
    logic             special, special_upd;
    logic             first, wr_last;

    // Shared scale: NaN if any element was Inf/NaN, else emax - EMAX_ELEM clamped at 0.
    function automatic logic [EXP_W-1:0] sat_scale(input logic [EXP_W-1:0] e,
                                                   input logic             sp);
        if (sp)
            return E8M0_NAN;
        return (e > EMAX_L) ? (e - EMAX_L) : '0;
    endfunction

    assign first   = (wr_idx == '0);
    assign wr_last = (wr_idx == LAST_IDX);

    always_comb begin
        emax_upd    = wr_v.exp;
        special_upd = (wr_v.exp == E8M0_NAN);
        if (!first) begin
            if (emax > wr_v.exp)
                emax_upd = emax;
            special_upd = special_upd || special;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BANK_EMPTY:   if (wr_en) state_nxt = wr_last ? BANK_FULL : BANK_FILLING;
            BANK_FILLING: if (wr_en && wr_last) state_nxt = BANK_FULL;
            // A refill may start in the same cycle the last element leaves.
            BANK_FULL:    if (rd_done) state_nxt = wr_en ? BANK_FILLING : BANK_EMPTY;
            default:      state_nxt = BANK_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BANK_EMPTY;
            emax    <= '0;
            special <= 1'b0;
            x       <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en) begin
                emax    <= emax_upd;
                special <= special_upd;
                if (wr_last)
                    x <= sat_scale(emax_upd, special_upd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_v;
    end

    assign full = (state == BANK_FULL);
    assign rd_v = mem[rd_idx];

endmodule

// File: rtl/mx_block_scan.sv
// FP32 block scanner: buffers N_ELEM elements, computes the E8M0 shared scale and
// replays V words. Define MX_SCAN_PINGPONG_EN for two banks (fill while draining).
module mx_block_scan
    import mx_pkg::*;
#(
    parameter int N_ELEM    = 32,
    parameter int EMAX_ELEM = EMAX_E3M2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [11:0]               out_v,
    output logic [7:0]                out_x,
    output logic [$clog2(N_ELEM)-1:0] out_idx,
    output logic                      out_last
);

    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
`ifdef MX_SCAN_PINGPONG_EN
    localparam logic PTR_TOGGLE = 1'b1;
`else
    localparam logic PTR_TOGGLE = 1'b0;
`endif

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             fill_ptr, drain_ptr;
    logic             accept, xfer, rd_done;
    logic             full0, full1, fill_full;
    v_word_t          in_v, rd_v0, rd_v1, drain_v;
    logic [7:0]       x0, x1, drain_x;
    logic             unused_mant;

    assign in_v        = {in_data[FP_SIGN_BIT], in_data[FP_EXP_MSB:FP_EXP_LSB],
                          in_data[FP_MANT_MSB -: V_MANT_W]};
    assign unused_mant = ^in_data[FP_MANT_MSB-V_MANT_W:0];

    assign fill_full = fill_ptr ? full1 : full0;
    assign in_ready  = !fill_full;
    assign accept    = in_valid && in_ready;

    assign out_valid = drain_ptr ? full1 : full0;
    assign xfer      = out_valid && out_ready;
    assign rd_done   = xfer && (rd_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wr_idx == LAST_IDX)
                    fill_ptr <= fill_ptr ^ PTR_TOGGLE;
            end
            if (xfer) begin
                rd_idx <= rd_idx + IDX_W'(1);
                if (rd_idx == LAST_IDX)
                    drain_ptr <= drain_ptr ^ PTR_TOGGLE;
            end
        end
    end

    mx_scan_bank #(.N_ELEM(N_ELEM), .EMAX_ELEM(EMAX_ELEM)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && !fill_ptr),
        .wr_idx  (wr_idx),
        .wr_v    (in_v),
        .rd_idx  (rd_idx),
        .rd_done (rd_done && !drain_ptr),
        .full    (full0),
        .rd_v    (rd_v0),
        .x       (x0)
    );

`ifdef MX_SCAN_PINGPONG_EN
    mx_scan_bank #(.N_ELEM(N_ELEM), .EMAX_ELEM(EMAX_ELEM)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && fill_ptr),
        .wr_idx  (wr_idx),
        .wr_v    (in_v),
        .rd_idx  (rd_idx),
        .rd_done (rd_done && drain_ptr),
        .full    (full1),
        .rd_v    (rd_v1),
        .x       (x1)
    );
`else
    assign full1 = 1'b0;
    assign rd_v1 = '0;
    assign x1    = '0;
`endif

    // Outputs come straight from bank registers; zeroed while nothing is valid.
    assign drain_v  = drain_ptr ? rd_v1 : rd_v0;
    assign drain_x  = drain_ptr ? x1 : x0;
    assign out_v    = out_valid ? drain_v : '0;
    assign out_x    = out_valid ? drain_x : '0;
    assign out_idx  = rd_idx;
    assign out_last = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_mx_block_scan.sv
// Scoreboard bench for mx_block_scan: a block-level reference model predicts every
// output word; a separate monitor compares whatever the DUT presents.
module tb_mx_block_scan;

    localparam int N = 32;
`ifdef MX_SCAN_PINGPONG_EN
    localparam int BP_ACCEPTS = 64;
`else
    localparam int BP_ACCEPTS = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_v;
    logic [7:0]  out_x;
    logic [4:0]  out_idx;
    logic        out_last;

    typedef struct packed {
        logic [11:0] v;
        logic [7:0]  x;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] part[$];
    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    bit          chk_valid_next = 0;
    int          ready_mode = 1;

    mx_block_scan #(.N_ELEM(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v     (out_v),
        .out_x     (out_x),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a completed block yields N words, all tagged with one scale.
    function automatic void push_block();
        int   emax = 0;
        bit   sp = 0;
        int   xs;
        exp_t e;
        foreach (part[i]) begin
            int ex = int'(part[i][30:23]);
            if (ex > emax) emax = ex;
            if (ex == 255) sp = 1;
        end
        xs = sp ? 255 : ((emax > 4) ? emax - 4 : 0);
        foreach (part[i]) begin
            e.v    = {part[i][31], part[i][30:23], part[i][22:20]};
            e.x    = xs[7:0];
            e.idx  = i[4:0];
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Input observer feeding the model.
    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            chk_valid_next = 0;
        end else begin
            if (chk_valid_next) begin
                check("latency_out_valid", {63'd0, out_valid}, 64'd1);
                chk_valid_next = 0;
            end
            if (in_valid && in_ready) begin
                accepts++;
                part.push_back(in_data);
                if (part.size() == N) begin
                    push_block();
                    part.delete();
                    chk_valid_next = 1;
                end
            end
        end
    end

    // Output monitor; comparing every valid cycle also covers hold under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check("out_word", 64'({out_v, out_x, out_idx, out_last}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=0 required=1 at %0t", $time);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && c < 4000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_elem(input int emax_lim);
        logic [31:0] r;
        int          e;
        r = $urandom;
        e = $urandom_range(0, emax_lim);
        r[30:23] = e[7:0];
        return r;
    endfunction

    task automatic send_bounded_block(input int emax_val);
        int pos = $urandom_range(0, N - 1);
        logic [31:0] d;
        for (int i = 0; i < N; i++) begin
            d = rnd_elem(emax_val);
            if (i == pos) d[30:23] = emax_val[7:0];
            send(d);
        end
    endtask

    initial begin
        logic [31:0] d;
        bit          ok;
        int          a0;
        int          pos;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_v",     64'(out_v),         64'd0);
        check("rst_out_x",     64'(out_x),         64'd0);
        check("rst_out_idx",   64'(out_idx),       64'd0);
        check("rst_out_last",  {63'd0, out_last},  64'd0);
        @(posedge clk);
        #1;

        // All ones
        ready_mode = 1;
        for (int i = 0; i < N; i++) send(32'h3F80_0000);
        wait_drain();

        // Mixed block with one +Inf
        pos = $urandom_range(0, N - 1);
        for (int i = 0; i < N; i++) send((i == pos) ? 32'h7F80_0000 : 32'h3F80_0000);
        wait_drain();

        // All zero, drained under random backpressure
        ready_mode = 2;
        for (int i = 0; i < N; i++) send(32'h0000_0000);
        wait_drain();

        // Sustained backpressure
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        a0       = accepts;
        in_data  = $urandom;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) in_data = $urandom;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", 64'(accepts - a0), 64'(BP_ACCEPTS));
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        ready_mode = 1;
        wait_drain();

        // Mid-block reset
        for (int i = 0; i < 10; i++) send(rnd_elem(200));
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_in_ready",  {63'd0, in_ready},  64'd1);
        check("mrst_out_idx",   64'(out_idx),       64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) send(32'h4000_0000);
        wait_drain();

        // Back-to-back blocks with different maxima
        ready_mode = 1;
        send_bounded_block(130);
        send_bounded_block(100);
        wait_drain();

        // Random blocks, specials and zeros mixed in, random output readiness
        ready_mode = 2;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) begin
                d = $urandom;
                case ($urandom_range(0, 9))
                    0:       d[30:23] = 8'hFF;
                    1:       d[30:23] = 8'h00;
                    default: ;
                endcase
                if (b == 1 && d[30:23] == 8'hFF) d[30:23] = 8'h7E;
                send(d);
            end
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
